// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer for the IF stage: combinational lookup,
// ID-stage resolution write-back, global invalidate and a saturating mispredict counter.
module branch_target_buffer #(
    parameter int ADDR_W  = 64,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2,
    parameter int PERF_W  = 32
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [ADDR_W-1:0] lkp_pc,
    output logic              lkp_taken,
    output logic              lkp_hit,
    output logic [ADDR_W-1:0] lkp_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_taken,
    input  logic              upd_mispredict,
    input  logic              inv_all,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_WEAK = CNT_W'(1) << (CNT_W - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_dec(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b0}}) ? c : c - CNT_W'(1);
    endfunction

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [ADDR_W-1:0]  target_q [ENTRIES];
    logic [ADDR_W-1:0]  target_d [ENTRIES];
    logic [CNT_W-1:0]   cnt_q    [ENTRIES];
    logic [CNT_W-1:0]   cnt_d    [ENTRIES];
    logic [PERF_W-1:0]  perf_q, perf_d;

    logic [IDX_W-1:0] lkp_idx_s, upd_idx_s;
    logic [TAG_W-1:0] lkp_tag_s, upd_tag_s;
    logic             upd_hit_s;
    logic             unused_pc_bits_s;

    assign lkp_idx_s = lkp_pc[IDX_W+1:2];
    assign lkp_tag_s = lkp_pc[ADDR_W-1:IDX_W+2];
    assign upd_idx_s = upd_pc[IDX_W+1:2];
    assign upd_tag_s = upd_pc[ADDR_W-1:IDX_W+2];
    // Word-aligned PCs only; the byte offset carries no information here.
    assign unused_pc_bits_s = ^{lkp_pc[1:0], upd_pc[1:0]};

    assign upd_hit_s  = valid_q[upd_idx_s] && (tag_q[upd_idx_s] == upd_tag_s);

    // Lookup reads registered state only, so a same-cycle update is not visible.
    assign lkp_hit    = valid_q[lkp_idx_s] && (tag_q[lkp_idx_s] == lkp_tag_s);
    assign lkp_taken  = lkp_hit && cnt_q[lkp_idx_s][CNT_W-1];
    assign lkp_target = lkp_hit ? target_q[lkp_idx_s] : {ADDR_W{1'b0}};

    assign perf_mispredicts = perf_q;

    // Next-state for the table: resolution write-back, then invalidate overrides valid bits.
    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        case ({upd_valid, upd_hit_s, upd_taken})
            3'b111: begin
                cnt_d[upd_idx_s]    = sat_inc(cnt_q[upd_idx_s]);
                target_d[upd_idx_s] = upd_target;
            end
            3'b110: begin
                cnt_d[upd_idx_s] = sat_dec(cnt_q[upd_idx_s]);
            end
            3'b101: begin
                valid_d[upd_idx_s]  = 1'b1;
                tag_d[upd_idx_s]    = upd_tag_s;
                target_d[upd_idx_s] = upd_target;
                cnt_d[upd_idx_s]    = CNT_WEAK;
            end
            default: begin
                valid_d = valid_q;
            end
        endcase
        valid_d = inv_all ? {ENTRIES{1'b0}} : valid_d;
    end

    // Next-state for the mispredict counter, holding at all-ones.
    always_comb begin
        perf_d = perf_q;
        if (upd_valid && upd_mispredict && (perf_q != {PERF_W{1'b1}})) begin
            perf_d = perf_q + PERF_W'(1);
        end else begin
            perf_d = perf_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            valid_q <= {ENTRIES{1'b0}};
            perf_q  <= {PERF_W{1'b0}};
            for (int i = 0; i < ENTRIES; i++) begin
                tag_q[i]    <= {TAG_W{1'b0}};
                target_q[i] <= {ADDR_W{1'b0}};
                cnt_q[i]    <= {CNT_W{1'b0}};
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            perf_q   <= perf_d;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed bench for branch_target_buffer; a second instance with a 3-bit
// mispredict counter shares all inputs to exercise counter saturation.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        arst;
    logic [63:0] lkp_pc;
    logic        lkp_taken, lkp_hit;
    logic [63:0] lkp_target;
    logic        upd_valid;
    logic [63:0] upd_pc, upd_target;
    logic        upd_taken, upd_mispredict, inv_all;
    logic [31:0] perf;
    logic        s_taken, s_hit;
    logic [63:0] s_target;
    logic [2:0]  s_perf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_target_buffer #(.ADDR_W(64), .ENTRIES(16), .CNT_W(2), .PERF_W(32)) dut (
        .clk(clk), .arst(arst), .lkp_pc(lkp_pc), .lkp_taken(lkp_taken), .lkp_hit(lkp_hit),
        .lkp_target(lkp_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .inv_all(inv_all), .perf_mispredicts(perf)
    );

    branch_target_buffer #(.ADDR_W(64), .ENTRIES(16), .CNT_W(2), .PERF_W(3)) dut_small (
        .clk(clk), .arst(arst), .lkp_pc(lkp_pc), .lkp_taken(s_taken), .lkp_hit(s_hit),
        .lkp_target(s_target), .upd_valid(upd_valid), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .inv_all(inv_all), .perf_mispredicts(s_perf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lkp(input string tag, input logic [63:0] pc, input logic eh,
                           input logic et, input logic [63:0] etg);
        lkp_pc = pc;
        #1;
        chk({tag, ".hit"}, {63'd0, lkp_hit}, {63'd0, eh});
        chk({tag, ".taken"}, {63'd0, lkp_taken}, {63'd0, et});
        chk({tag, ".target"}, lkp_target, etg);
        chk({tag, ".s_hit"}, {63'd0, s_hit}, {63'd0, eh});
    endtask

    task automatic upd(input logic [63:0] pc, input logic [63:0] tgt, input logic tk,
                       input logic mis);
        upd_pc         = pc;
        upd_target     = tgt;
        upd_taken      = tk;
        upd_mispredict = mis;
        upd_valid      = 1'b1;
        tick();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
    endtask

    initial begin
        arst = 1'b1; lkp_pc = 64'd0; upd_valid = 1'b0; upd_pc = 64'd0;
        upd_target = 64'd0; upd_taken = 1'b0; upd_mispredict = 1'b0; inv_all = 1'b0;
        repeat (3) @(posedge clk);
        #1 arst = 1'b0;

        chk_lkp("reset", 64'h100, 1'b0, 1'b0, 64'h0);
        chk("reset.perf", {32'd0, perf}, 64'd0);

        // Allocation, alias miss
        upd(64'h100, 64'h200, 1'b1, 1'b0);
        chk_lkp("alloc", 64'h100, 1'b1, 1'b1, 64'h200);
        chk_lkp("alias", 64'h140, 1'b0, 1'b0, 64'h0);

        // Counter walk: 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11 -> 11 -> 10 -> 01
        upd(64'h100, 64'h999, 1'b0, 1'b0);
        chk_lkp("nt1", 64'h100, 1'b1, 1'b0, 64'h200);
        upd(64'h100, 64'h999, 1'b0, 1'b0);
        chk_lkp("nt2", 64'h100, 1'b1, 1'b0, 64'h200);
        upd(64'h100, 64'h999, 1'b0, 1'b0);
        chk_lkp("nt_sat", 64'h100, 1'b1, 1'b0, 64'h200);
        upd(64'h100, 64'h300, 1'b1, 1'b0);
        chk_lkp("t1", 64'h100, 1'b1, 1'b0, 64'h300);
        upd(64'h100, 64'h300, 1'b1, 1'b0);
        chk_lkp("t2", 64'h100, 1'b1, 1'b1, 64'h300);
        upd(64'h100, 64'h300, 1'b1, 1'b0);
        chk_lkp("t3", 64'h100, 1'b1, 1'b1, 64'h300);
        upd(64'h100, 64'h300, 1'b1, 1'b0);
        chk_lkp("t_sat", 64'h100, 1'b1, 1'b1, 64'h300);
        upd(64'h100, 64'h999, 1'b0, 1'b0);
        chk_lkp("top_dec1", 64'h100, 1'b1, 1'b1, 64'h300);
        upd(64'h100, 64'h999, 1'b0, 1'b0);
        chk_lkp("top_dec2", 64'h100, 1'b1, 1'b0, 64'h300);

        // Not-taken miss never evicts; taken miss does
        upd(64'h140, 64'h500, 1'b0, 1'b0);
        chk_lkp("nt_miss_keep", 64'h100, 1'b1, 1'b0, 64'h300);
        upd(64'h140, 64'h500, 1'b1, 1'b0);
        chk_lkp("evict_old", 64'h100, 1'b0, 1'b0, 64'h0);
        chk_lkp("evict_new", 64'h140, 1'b1, 1'b1, 64'h500);

        inv_all = 1'b1;
        tick();
        inv_all = 1'b0;
        chk_lkp("inv", 64'h140, 1'b0, 1'b0, 64'h0);

        // Same-cycle lookup sees pre-update state
        tick();
        upd_pc = 64'h100; upd_target = 64'h200; upd_taken = 1'b1; upd_valid = 1'b1;
        chk_lkp("same_cyc", 64'h100, 1'b0, 1'b0, 64'h0);
        tick();
        upd_valid = 1'b0;
        chk_lkp("same_cyc_next", 64'h100, 1'b1, 1'b1, 64'h200);

        // Invalidate wins over a coincident allocation; mispredict still counted
        inv_all = 1'b1;
        upd(64'h100, 64'h200, 1'b1, 1'b1);
        inv_all = 1'b0;
        chk_lkp("inv_wins", 64'h100, 1'b0, 1'b0, 64'h0);
        chk("perf1", {32'd0, perf}, 64'd1);

        for (int i = 0; i < 5; i++) upd(64'h800, 64'h0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) upd(64'h800, 64'h0, 1'b0, 1'b0);
        chk("perf6", {32'd0, perf}, 64'd6);
        chk("s_perf6", {61'd0, s_perf}, 64'd6);
        for (int i = 0; i < 3; i++) upd(64'h800, 64'h0, 1'b0, 1'b1);
        chk("perf9", {32'd0, perf}, 64'd9);
        chk("s_perf_sat", {61'd0, s_perf}, 64'd7);
        chk_lkp("nt_miss_noalloc", 64'h800, 1'b0, 1'b0, 64'h0);

        // Asynchronous reset in the middle of an update burst
        upd(64'h104, 64'h10, 1'b1, 1'b0);
        upd(64'h100, 64'h20, 1'b1, 1'b1);
        chk_lkp("pre_rst_a", 64'h104, 1'b1, 1'b1, 64'h10);
        upd_pc = 64'h108; upd_target = 64'h30; upd_taken = 1'b1; upd_valid = 1'b1;
        chk_lkp("pre_rst_b", 64'h100, 1'b1, 1'b1, 64'h20);
        arst = 1'b1;
        #1;
        chk("rst_hit", {63'd0, lkp_hit}, 64'd0);
        chk("rst_taken", {63'd0, lkp_taken}, 64'd0);
        chk("rst_target", lkp_target, 64'd0);
        chk("rst_perf", {32'd0, perf}, 64'd0);
        chk("rst_s_perf", {61'd0, s_perf}, 64'd0);
        tick();
        upd_valid = 1'b0;
        arst = 1'b0;
        tick();
        chk_lkp("post_rst_a", 64'h100, 1'b0, 1'b0, 64'h0);
        chk_lkp("post_rst_b", 64'h104, 1'b0, 1'b0, 64'h0);
        chk_lkp("post_rst_c", 64'h108, 1'b0, 1'b0, 64'h0);
        chk("post_rst_perf", {32'd0, perf}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
